topo2a_ad_proj_mul_pipe: RTL

TOPO2A_AD_PROJ_MUL_PIPE -- requirements
Module: topo2a_ad_proj_mul_pipe

---
 rtl/topo2a_ad_proj_pkg.sv | 6 +
 rtl/topo2a_ad_proj_narrow.sv | 25 ++
 rtl/topo2a_ad_proj_mul_pipe.sv | 97 +++++++++
 3 files changed

// File: rtl/topo2a_ad_proj_pkg.sv
// topo2a_ad_proj_pkg: constants shared by the multiply pipeline and its narrowing stage
package topo2a_ad_proj_pkg;
  localparam int MAX_NUM_STAGE = 8;
  localparam int WRAP_MODE = 0;
  localparam int SAT_MODE = 1;
endpackage

// File: rtl/topo2a_ad_proj_narrow.sv
// topo2a_ad_proj_narrow: signed narrowing to OUT_W bits by wrap or clamp, flagging out-of-range values
module topo2a_ad_proj_narrow
  import topo2a_ad_proj_pkg::*;
#(
  parameter int IN_W   = 23,
  parameter int OUT_W  = 19,
  parameter int SAT_EN = WRAP_MODE
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout,
  output logic                    o_ovf
);
  if (IN_W <= OUT_W) begin : g_wide
    assign o_dout = OUT_W'(i_din);
    assign o_ovf  = 1'b0;
  end else begin : g_narrow
    logic                    w_ovf;
    logic signed [OUT_W-1:0] w_clamp;
    // in range only when every dropped bit repeats the kept sign bit
    assign w_ovf   = i_din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){i_din[IN_W-1]}};
    assign w_clamp = {i_din[IN_W-1], {(OUT_W-1){~i_din[IN_W-1]}}};
    assign o_dout  = (SAT_EN == SAT_MODE && w_ovf) ? w_clamp : i_din[OUT_W-1:0];
    assign o_ovf   = w_ovf;
  end
endmodule

// File: rtl/topo2a_ad_proj_mul_pipe.sv
// topo2a_ad_proj_mul_pipe: valid/ready signed multiply (or multiply-accumulate) pipeline
module topo2a_ad_proj_mul_pipe
  import topo2a_ad_proj_pkg::*;
#(
  parameter int DIN0_WIDTH = 15,
  parameter int DIN1_WIDTH = 5,
  parameter int DOUT_WIDTH = 19,
  parameter int NUM_STAGE  = 3,
  parameter int SAT_EN     = 0,
  parameter int ACC_EN     = 0,
  parameter int ACC_GUARD  = 4
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         ovf
);
  localparam int NS = (NUM_STAGE < 1) ? 1 : (NUM_STAGE > MAX_NUM_STAGE) ? MAX_NUM_STAGE : NUM_STAGE;
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int AW = (DOUT_WIDTH + ACC_GUARD > PW) ? DOUT_WIDTH + ACC_GUARD : PW;
  logic                         w_adv, w_v, w_l, w_emit, w_ovf;
  logic                         r_vld, r_ovf;
  logic signed [PW-1:0]         w_mul, w_p;
  logic signed [AW-1:0]         w_sum, r_acc;
  logic signed [DOUT_WIDTH-1:0] w_dout, r_dout;
  assign w_adv    = out_ready | ~r_vld;
  assign in_ready = w_adv;
  assign w_mul    = PW'(din0) * PW'(din1);
  // NS-1 product registers feed the output register, giving NS registers end to end
  if (NS == 1) begin : g_comb
    assign w_p = w_mul;
    assign w_v = in_valid;
    assign w_l = in_last;
  end else begin : g_pipe
    logic signed [PW-1:0] r_p [NS-1];
    logic                 r_v [NS-1];
    logic                 r_l [NS-1];
    for (genvar s = 0; s < NS - 1; s++) begin : g_stage
      logic signed [PW-1:0] w_pi;
      logic                 w_vi, w_li;
      if (s == 0) begin : g_first
        assign w_pi = w_mul;
        assign w_vi = in_valid;
        assign w_li = in_last;
      end else begin : g_next
        assign w_pi = r_p[s-1];
        assign w_vi = r_v[s-1];
        assign w_li = r_l[s-1];
      end
      always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
          r_p[s] <= '0;
          r_v[s] <= 1'b0;
          r_l[s] <= 1'b0;
        end else if (w_adv) begin
          r_p[s] <= w_pi;
          r_v[s] <= w_vi;
          r_l[s] <= w_li;
        end
    end
    assign w_p = r_p[NS-2];
    assign w_v = r_v[NS-2];
    assign w_l = r_l[NS-2];
  end
  assign w_sum  = (ACC_EN != 0 ? r_acc : '0) + AW'(w_p);
  assign w_emit = w_v & ((ACC_EN == 0) | w_l);
  topo2a_ad_proj_narrow #(.IN_W(AW), .OUT_W(DOUT_WIDTH), .SAT_EN(SAT_EN)) u_narrow (
    .i_din (w_sum),
    .o_dout(w_dout),
    .o_ovf (w_ovf)
  );
  // every update is gated by w_adv, so a stalled pending result never re-adds into r_acc
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      r_vld  <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_acc  <= '0;
    end else if (w_adv) begin
      r_vld <= w_emit;
      if (w_emit) begin
        r_dout <= w_dout;
        r_ovf  <= w_ovf;
      end
      if (ACC_EN != 0 && w_v) r_acc <= w_l ? '0 : w_sum;
    end
  assign dout      = r_dout;
  assign ovf       = r_ovf;
  assign out_valid = r_vld;
endmodule
